// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and constants for the two-master bus arbiter
package mips_bus_pkg;

    // Arbiter FSM: no owner, or the slave granted to master 0 / master 1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    // Read data returned to a master whose transfer was aborted by the stall timer.
    localparam logic [31:0] ABORT_READDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// rtl/mips_bus_arbiter_if.sv - Avalon-style bus bundle: two CPU master ports and one slave port
//
// Signals: m0_* (data port) and m1_* (instruction-fetch port): address, read, write,
//          writedata, byteenable toward the arbiter; waitrequest, readdata back.
//          s_*: address, read, write, writedata, byteenable toward the slave;
//          s_waitrequest, s_readdata back.
// Modports: arb    - the arbiter itself
//           master - the CPU side driving both master ports
//           slave  - the memory side answering the slave port
interface mips_bus_arbiter_if
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic [ADDR_W-1:0]   m0_address,    m1_address;
    logic                m0_read,       m1_read;
    logic                m0_write,      m1_write;
    logic [DATA_W-1:0]   m0_writedata,  m1_writedata;
    logic [DATA_W/8-1:0] m0_byteenable, m1_byteenable;
    logic                m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0]   m0_readdata,   m1_readdata;

    logic [ADDR_W-1:0]   s_address;
    logic                s_read;
    logic                s_write;
    logic [DATA_W-1:0]   s_writedata;
    logic [DATA_W/8-1:0] s_byteenable;
    logic                s_waitrequest;
    logic [DATA_W-1:0]   s_readdata;

    modport arb (
        input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        output m0_waitrequest, m0_readdata, m1_waitrequest, m1_readdata,
        output s_address, s_read, s_write, s_writedata, s_byteenable,
        input  s_waitrequest, s_readdata
    );

    modport master (
        output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        input  m0_waitrequest, m0_readdata, m1_waitrequest, m1_readdata
    );

    modport slave (
        input  s_address, s_read, s_write, s_writedata, s_byteenable,
        output s_waitrequest, s_readdata
    );

endinterface

// File: rtl/mips_bus_stall_timer.sv
// rtl/mips_bus_stall_timer.sv - 10-bit stall counter for the arbiter abort path (built only with MIPS_BUS_ARB_TIMEOUT_EN)
//
// Ports: clk, reset (async, active-high); clear (highest priority), inc; limit (10 bits);
//        expired - count currently equals limit.
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
module mips_bus_stall_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    input  logic [9:0] limit,
    output logic       expired
);
    logic [9:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 10'd1;
        end
    end

    assign expired = (count == limit);

endmodule
`endif

// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - round-robin arbiter granting one Avalon-style slave to two CPU master ports
//
// Ports: clk, reset (async, active-high); bus (mips_bus_arbiter_if.arb) carrying both
//        master ports and the slave port; timeout_err - sticky stall-abort flag.
// Optional: MIPS_BUS_ARB_TIMEOUT_EN builds the stall timer that aborts a grant after
//           TIMEOUT stalled cycles; without it timeout_err is tied low.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    mips_bus_arbiter_if.arb  bus,
    output logic             timeout_err
);
    if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("mips_bus_arbiter: TIMEOUT must be within 1..1023");
    end
    if (ADDR_W < 1 || DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_width
        $error("mips_bus_arbiter: ADDR_W must be >= 1 and DATA_W a multiple of 8");
    end

    arb_state_t state, state_next;
    logic       last_grant, last_grant_next;
    logic       req0, req1, req_g, granted, abort, done;

    assign req0    = bus.m0_read | bus.m0_write;
    assign req1    = bus.m1_read | bus.m1_write;
    assign granted = (state != IDLE);
    assign req_g   = (state == GNT0) ? req0 : (state == GNT1) ? req1 : 1'b0;
    // An abort ends the transfer exactly like a real completion.
    assign done    = req_g & (~bus.s_waitrequest | abort);

`ifdef MIPS_BUS_ARB_TIMEOUT_EN
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(ABORT_READDATA);
    logic expired;

    mips_bus_stall_timer u_stall_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (~granted | (state_next != state)),
        .inc     (granted & req_g & bus.s_waitrequest),
        .limit   (10'(TIMEOUT)),
        .expired (expired)
    );

    assign abort = granted & req_g & expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (abort) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                // On a tie the master that did not win last time goes first.
                if (req0 && (!req1 || last_grant)) begin
                    state_next = GNT0;
                end else if (req1) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (done) begin
                    last_grant_next = 1'b0;
                    state_next      = req1 ? GNT1 : IDLE;
                end else if (!req0) begin
                    state_next = IDLE;
                end
            end
            GNT1: begin
                if (done) begin
                    last_grant_next = 1'b1;
                    state_next      = req0 ? GNT0 : IDLE;
                end else if (!req1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.s_address      = '0;
        bus.s_read         = 1'b0;
        bus.s_write        = 1'b0;
        bus.s_writedata    = '0;
        bus.s_byteenable   = '0;
        bus.m0_waitrequest = 1'b1;
        bus.m1_waitrequest = 1'b1;
        bus.m0_readdata    = '0;
        bus.m1_readdata    = '0;
        case (state)
            GNT0: begin
                bus.s_address      = bus.m0_address;
                bus.s_read         = bus.m0_read;
                bus.s_write        = bus.m0_write;
                bus.s_writedata    = bus.m0_writedata;
                bus.s_byteenable   = bus.m0_byteenable;
                bus.m0_waitrequest = bus.s_waitrequest;
                bus.m0_readdata    = bus.s_readdata;
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
                if (abort) begin
                    bus.s_read         = 1'b0;
                    bus.s_write        = 1'b0;
                    bus.m0_waitrequest = 1'b0;
                    bus.m0_readdata    = ABORT_DATA;
                end
`endif
            end
            GNT1: begin
                bus.s_address      = bus.m1_address;
                bus.s_read         = bus.m1_read;
                bus.s_write        = bus.m1_write;
                bus.s_writedata    = bus.m1_writedata;
                bus.s_byteenable   = bus.m1_byteenable;
                bus.m1_waitrequest = bus.s_waitrequest;
                bus.m1_readdata    = bus.s_readdata;
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
                if (abort) begin
                    bus.s_read         = 1'b0;
                    bus.s_write        = 1'b0;
                    bus.m1_waitrequest = 1'b0;
                    bus.m1_readdata    = ABORT_DATA;
                end
`endif
            end
            default: ;
        endcase
    end

endmodule
